pic27ch_sched: RTL and testbench
================================

PIC27CH_SCHED -- requirements
Module: pic27ch_sched

Interface
REQ-001 Parameter: NCH, default 9, number of interrupt channels per priority level.
REQ-002 Parameter: ACK_TIMEOUT, default 15, range 1..15, cycles irq_valid may wait for irq_ack before abandoning.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: req_a  input  NCH  level-A (highest) requests; bit 0 is the highest-priority channel.
REQ-006 Port: req_b  input  NCH  level-B requests.
REQ-007 Port: req_c  input  NCH  level-C (lowest) requests.
REQ-008 Port: chan_en  input  NCH  per-channel enable mask, applied to all three levels.
REQ-009 Port: irq_ack  input  1  consumer acknowledge of the current grant.
REQ-010 Port: irq_valid  output  1  a grant is presented.
REQ-011 Port: irq_chan  output  4  granted channel index, 0..NCH-1.
REQ-012 Port: irq_level  output  2  granted level: 0=A, 1=B, 2=C.
REQ-013 Port: pend_any  output  1  OR of all enabled pending bits.
REQ-014 Port: timeout_err  output  1  one-cycle pulse when a grant is abandoned.

Function
REQ-015 Pending store: 3xNCH flops; bit set on any rising edge where the matching req bit is 1, regardless of chan_en.
REQ-016 Pending bit cleared only by an accepted ack of that exact channel and level; when set and clear coincide, set wins.
REQ-017 Eligible = pending AND chan_en; arbitration picks any eligible A over any B, any B over any C, and the lowest channel index within a level.
REQ-018 FSM states: IDLE, ARB, GRANT.
REQ-019 IDLE -> ARB when eligible is non-zero; otherwise remain in IDLE.
REQ-020 ARB, 1 cycle: latch winner into irq_chan/irq_level and go to GRANT; if eligible has become zero, return to IDLE.
REQ-021 GRANT: irq_valid=1; irq_chan and irq_level are held stable until the grant leaves GRANT.
REQ-022 GRANT -> IDLE on irq_ack=1: clear the granted pending bit; irq_valid=0 from the next cycle.
REQ-023 Latency: req bit sampled at edge k; ARB entered at edge k+1; irq_valid=1 after edge k+2, assuming IDLE and no higher winner.
REQ-024 Minimum back-to-back grant spacing is 3 cycles: GRANT, IDLE, ARB.
REQ-025 irq_ack while not in GRANT is ignored.
REQ-026 Timeout: a 4-bit counter zeroes on GRANT entry and increments each GRANT cycle without ack.
REQ-027 When the counter reaches ACK_TIMEOUT-1 without ack: go to IDLE, pulse timeout_err for 1 cycle, and leave the pending bit set.
REQ-028 Ack on the same cycle as expiry: the ack wins and timeout_err stays 0.
REQ-029 A grant is not preempted by a higher-priority arrival or by chan_en falling; it ends only by ack or timeout.
REQ-030 pend_any is registered and reflects eligibility as of the previous edge.

Reset
REQ-031 rst_n=0 immediately forces: pending=0, FSM=IDLE, counter=0, irq_valid=0, irq_chan=0, irq_level=0, pend_any=0, timeout_err=0.
REQ-032 Reset during GRANT drops irq_valid asynchronously and discards the grant without a timeout_err pulse.
REQ-033 After rst_n rises, the first request is sampled on the first rising edge.

Verification
REQ-034 chan_en=all 1s, req_c[5] pulsed for 1 cycle -> irq_valid=1, irq_chan=5, irq_level=2 two edges later; ack -> pend_any=0.
REQ-035 req_b[3] and req_a[7] asserted on the same cycle -> first grant chan 7 level 0; after ack, grant chan 3 level 1 exactly 3 cycles later.
REQ-036 req_a[0] asserted during an active grant of chan 4 level 2 -> chan 4 held stable until ack; next grant is chan 0 level 0.
REQ-037 ACK_TIMEOUT=4, no ack -> irq_valid=0 after 4 GRANT cycles with one timeout_err pulse; same channel re-granted 2 cycles later.
REQ-038 chan_en[2]=0 with req_a[2] pending -> no grant; raising chan_en[2] -> grant chan 2 level 0 two edges later.
REQ-039 rst_n dropped mid-GRANT -> all outputs 0 at once; no timeout_err; no grant after release until a new request arrives.

Source files
------------

// File: rtl/pic27ch_sched.sv
// Three-level, NCH-channel interrupt scheduler: sticky pending flops, fixed-priority
// arbitration (A > B > C, lowest channel first) and a held grant with ack timeout.
module pic27ch_sched #(
  parameter int NCH         = 9,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   req_a,
  input  logic [NCH-1:0]   req_b,
  input  logic [NCH-1:0]   req_c,
  input  logic [NCH-1:0]   chan_en,
  input  logic             irq_ack,
  output logic             irq_valid,
  output logic [3:0]       irq_chan,
  output logic [1:0]       irq_level,
  output logic             pend_any,
  output logic             timeout_err,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_GRANT = 2'd2
  } state_t;

  localparam logic [3:0] TMO_LAST = 4'(ACK_TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [2:0][NCH-1:0]   pend_q, pend_d;
  logic [2:0][NCH-1:0]   elig;
  logic [2:0][NCH-1:0]   clr;
  logic [3:0]            cnt_q, cnt_d;
  logic [3:0]            chan_q, chan_d;
  logic [1:0]            lvl_q, lvl_d;
  logic                  pend_any_q;
  logic                  tmo_q, tmo_d;
  logic                  win_found;
  logic [3:0]            win_chan;
  logic [1:0]            win_lvl;

  always_comb begin
    for (int l = 0; l < 3; l++) begin
      elig[l] = pend_q[l] & chan_en;
    end
  end

  // Scan from lowest priority upward so the last hit is the highest-priority winner.
  always_comb begin
    win_found = 1'b0;
    win_chan  = '0;
    win_lvl   = '0;
    for (int l = 2; l >= 0; l--) begin
      for (int c = NCH - 1; c >= 0; c--) begin
        if (elig[l][c]) begin
          win_found = 1'b1;
          win_chan  = 4'(c);
          win_lvl   = 2'(l);
        end
      end
    end
  end

  always_comb begin
    clr = '0;
    if (state_q == S_GRANT && irq_ack) begin
      clr[lvl_q][chan_q] = 1'b1;
    end
  end

  // A new request on the same edge as its clearing ack keeps the bit set.
  assign pend_d = (pend_q & ~clr) | {req_c, req_b, req_a};

  // Handshake: irq_valid stays high with irq_chan/irq_level frozen until the cycle
  // in which irq_ack is sampled high (accepted) or the timeout abandons the grant.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chan_d  = chan_q;
    lvl_d   = lvl_q;
    tmo_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) state_d = S_ARB;
      end
      S_ARB: begin
        if (win_found) begin
          state_d = S_GRANT;
          chan_d  = win_chan;
          lvl_d   = win_lvl;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        if (irq_ack) begin
          state_d = S_IDLE;
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pend_q     <= '0;
      cnt_q      <= '0;
      chan_q     <= '0;
      lvl_q      <= '0;
      pend_any_q <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      chan_q     <= chan_d;
      lvl_q      <= lvl_d;
      pend_any_q <= win_found;
      tmo_q      <= tmo_d;
    end
  end

  assign irq_valid   = (state_q == S_GRANT);
  assign irq_chan    = chan_q;
  assign irq_level   = lvl_q;
  assign pend_any    = pend_any_q;
  assign timeout_err = tmo_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_pic27ch_sched.sv
// Bench for pic27ch_sched: directed scenarios plus random traffic, all checked by a
// transaction-level reference model feeding expectation queues read by a monitor.
module tb_pic27ch_sched;

  localparam int NCH = 9;
  localparam int AT  = 4;
  localparam logic [NCH-1:0] ALL = '1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] req_a = '0, req_b = '0, req_c = '0, chan_en = '0;
  logic           irq_ack = 1'b0;
  logic           irq_valid, pend_any, timeout_err;
  logic [3:0]     irq_chan;
  logic [1:0]     irq_level;
  logic [1:0]     dbg_state;

  pic27ch_sched #(.NCH(NCH), .ACK_TIMEOUT(AT)) dut (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .chan_en(chan_en), .irq_ack(irq_ack), .irq_valid(irq_valid),
    .irq_chan(irq_chan), .irq_level(irq_level), .pend_any(pend_any),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_vec = 0;
  int n_err = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct { int edge_no; bit pa; bit v; } cyc_t;
  typedef struct { int edge_no; int l; int c; } gnt_t;

  cyc_t eq[$];
  gnt_t gq[$];
  int   tq[$];

  bit [NCH-1:0] m_pend [3];
  bit           m_grant, m_arb;
  int           m_gl, m_gc, m_start;

  task automatic model_reset();
    for (int l = 0; l < 3; l++) m_pend[l] = '0;
    m_grant = 0;
    m_arb   = 0;
    eq.delete();
    gq.delete();
    tq.delete();
  endtask

  // Predicts the effect of the next rising edge from the inputs now applied.
  task automatic model_step();
    int           e;
    bit           any, found;
    int           wl, wc;
    bit [NCH-1:0] el [3];
    bit [NCH-1:0] rq [3];
    cyc_t         ce;
    gnt_t         ge;
    e = edge_n + 1;
    rq[0] = req_a; rq[1] = req_b; rq[2] = req_c;
    any = 0;
    for (int l = 0; l < 3; l++) begin
      el[l] = m_pend[l] & chan_en;
      if (el[l] != 0) any = 1;
    end
    if (m_grant) begin
      if (irq_ack) begin
        m_pend[m_gl][m_gc] = 1'b0;
        m_grant = 0;
      end else if (e == m_start + AT) begin
        m_grant = 0;
        tq.push_back(e);
      end
    end else if (m_arb) begin
      m_arb = 0;
      if (any) begin
        found = 0; wl = 0; wc = 0;
        for (int l = 0; l < 3 && !found; l++)
          for (int c = 0; c < NCH && !found; c++)
            if (el[l][c]) begin found = 1; wl = l; wc = c; end
        m_grant = 1; m_gl = wl; m_gc = wc; m_start = e;
        ge.edge_no = e; ge.l = wl; ge.c = wc;
        gq.push_back(ge);
      end
    end else if (any) begin
      m_arb = 1;
    end
    for (int l = 0; l < 3; l++) m_pend[l] = m_pend[l] | rq[l];
    ce.edge_no = e; ce.pa = any; ce.v = m_grant;
    eq.push_back(ce);
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply(input logic [NCH-1:0] a, b, c, en, input logic ack);
    req_a = a; req_b = b; req_c = c; chan_en = en; irq_ack = ack;
    model_step();
  endtask

  task automatic drive(input logic [NCH-1:0] a, b, c, en, input logic ack);
    @(negedge clk); #1;
    apply(a, b, c, en, ack);
  endtask

  task automatic idle(input int n, input logic ack);
    for (int i = 0; i < n; i++) drive('0, '0, '0, ALL, ack);
  endtask

  task automatic check_zero_outputs(input string tag);
    n_vec++;
    if ({irq_valid, irq_chan, irq_level, pend_any, timeout_err} !== 9'd0) begin
      n_err++;
      $display("FAIL %s: valid=%0b chan=%0d level=%0d pend_any=%0b timeout_err=%0b, want all 0",
               tag, irq_valid, irq_chan, irq_level, pend_any, timeout_err);
    end
  endtask

  task automatic pulse_reset(input int hold);
    @(negedge clk); #1;
    rst_n = 1'b0;
    req_a = '0; req_b = '0; req_c = '0; irq_ack = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    model_reset();
    repeat (hold) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [NCH-1:0] rnd_req();
    logic [NCH-1:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) r[i] = ($urandom_range(0, 23) == 0);
    return r;
  endfunction

  // ---------------- monitor ----------------
  initial begin : monitor
    bit   v_prev, rise, exp_to;
    int   h_c, h_l;
    cyc_t ce;
    gnt_t ge;
    v_prev = 0; h_c = 0; h_l = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        v_prev = 0;
      end else begin
        if (eq.size() > 0 && eq[0].edge_no == edge_n) begin
          ce = eq.pop_front();
          n_vec++;
          if (irq_valid !== ce.v || pend_any !== ce.pa) begin
            n_err++;
            $display("FAIL cycle e%0d: irq_valid=%0b pend_any=%0b, want %0b %0b",
                     edge_n, irq_valid, pend_any, ce.v, ce.pa);
          end
        end
        exp_to = (tq.size() > 0 && tq[0] == edge_n);
        if (exp_to) void'(tq.pop_front());
        n_vec++;
        if (timeout_err !== exp_to) begin
          n_err++;
          $display("FAIL timeout_err e%0d: got %0b, want %0b", edge_n, timeout_err, exp_to);
        end
        rise = irq_valid && !v_prev;
        if (gq.size() > 0 && gq[0].edge_no == edge_n) begin
          ge = gq.pop_front();
          n_vec++;
          if (!rise || int'(irq_chan) != ge.c || int'(irq_level) != ge.l) begin
            n_err++;
            $display("FAIL grant e%0d: new=%0b chan=%0d level=%0d, want new=1 chan=%0d level=%0d",
                     edge_n, rise, irq_chan, irq_level, ge.c, ge.l);
          end
        end else if (rise) begin
          n_vec++;
          n_err++;
          $display("FAIL grant e%0d: unexpected grant chan=%0d level=%0d, want none",
                   edge_n, irq_chan, irq_level);
        end
        if (irq_valid && v_prev) begin
          n_vec++;
          if (int'(irq_chan) != h_c || int'(irq_level) != h_l) begin
            n_err++;
            $display("FAIL hold e%0d: chan=%0d level=%0d, want %0d %0d",
                     edge_n, irq_chan, irq_level, h_c, h_l);
          end
        end
        if (rise) begin h_c = int'(irq_chan); h_l = int'(irq_level); end
        v_prev = irq_valid;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [NCH-1:0] en, a, b, c, one;
    model_reset();
    #3;
    check_zero_outputs("reset_t0");
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset_held");
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Low-priority single pulse, sampled on the very first edge after release.
    one = '0; one[5] = 1'b1;
    apply('0, '0, one, ALL, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(3, 1'b0);

    // Level A beats level B; the B grant follows 3 cycles after the ack.
    a = '0; a[7] = 1'b1; b = '0; b[3] = 1'b1;
    drive(a, b, '0, ALL, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(3, 1'b0);

    // Higher-priority arrival during a grant does not preempt it.
    c = '0; c[4] = 1'b1; a = '0; a[0] = 1'b1;
    drive('0, '0, c, ALL, 1'b0);
    idle(2, 1'b0);
    drive(a, '0, '0, ALL, 1'b0);
    idle(1, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(3, 1'b0);

    // No ack: timeout, pulse, then the same channel re-granted.
    a = '0; a[1] = 1'b1;
    drive(a, '0, '0, ALL, 1'b0);
    idle(12, 1'b0);
    idle(6, 1'b1);
    idle(3, 1'b0);

    // Masked channel waits until its enable is raised.
    a = '0; a[2] = 1'b1; en = ALL; en[2] = 1'b0;
    drive(a, '0, '0, en, 1'b0);
    for (int i = 0; i < 5; i++) drive('0, '0, '0, en, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(3, 1'b0);

    // Reset in the middle of a grant discards it.
    b = '0; b[6] = 1'b1;
    drive('0, b, '0, ALL, 1'b0);
    idle(3, 1'b0);
    pulse_reset(2);
    apply('0, '0, '0, ALL, 1'b0);
    idle(6, 1'b0);

    // Random traffic.
    en = ALL;
    for (int i = 0; i < 1500; i++) begin
      if (i % 150 == 0) en = ($urandom_range(0, 2) == 0) ? NCH'($urandom) : ALL;
      a = rnd_req(); b = rnd_req(); c = rnd_req();
      drive(a, b, c, en, $urandom_range(0, 3) == 0);
      if (i == 777) pulse_reset($urandom_range(1, 3));
    end

    // Drain: acknowledge everything that is still pending.
    idle(100, 1'b1);
    idle(4, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (eq.size() != 0 || gq.size() != 0 || tq.size() != 0 || pend_any !== 1'b0) begin
      n_err++;
      $display("FAIL drain: queued cyc=%0d grant=%0d tmo=%0d pend_any=%0b, want 0 0 0 0",
               eq.size(), gq.size(), tq.size(), pend_any);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
